fft_output_streamer: RTL and testbench

//  Drains a completed FFT frame from the two result banks (ram0 = even bins, ram1 = odd bins)

---
 rtl/fft_output_streamer.sv | 135 +++++++++++++
 tb/tb_fft_output_streamer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_output_streamer.sv
// Drains a finished FFT frame from the even/odd result banks and streams the bins
// in natural order on a valid/ready port, tagged with bin index and block exponent.
module fft_output_streamer #(
  parameter int FFT_N     = 10,
  parameter int FFT_DW    = 16,
  parameter int FFT_BFPDW = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [FFT_BFPDW-1:0]   ibfp,
  output logic                   busy,
  output logic                   done,
  output logic                   ract_ram0,
  output logic [FFT_N-2:0]       ra_ram0,
  input  logic [2*FFT_DW-1:0]    rdr_ram0,
  output logic                   ract_ram1,
  output logic [FFT_N-2:0]       ra_ram1,
  input  logic [2*FFT_DW-1:0]    rdr_ram1,
  output logic                   ovalid,
  input  logic                   oready,
  output logic [2*FFT_DW-1:0]    odata,
  output logic [FFT_N-1:0]       oindex,
  output logic                   olast,
  output logic [FFT_BFPDW-1:0]   obfp
);

  localparam int AW = FFT_N - 1;
  localparam int WW = 2 * FFT_DW;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    EMIT0,
    EMIT1
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [AW-1:0]        addr;
  logic [AW-1:0]        addr_nxt;
  logic [AW-1:0]        ra_q;
  logic [AW-1:0]        ra_cmb;
  logic [WW-1:0]        even_q;
  logic [WW-1:0]        odd_q;
  logic [FFT_BFPDW-1:0] bfp_q;
  logic                 done_q;
  logic                 rd_en;
  logic                 last;

  assign last = &addr;

  // The next pair is prefetched on the odd-bin handshake, so FETCH runs once per frame.
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    rd_en     = 1'b0;
    ra_cmb    = ra_q;
    ovalid    = 1'b0;
    odata     = '0;
    oindex    = '0;
    olast     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = FETCH;
          addr_nxt  = '0;
        end
      end
      FETCH: begin
        rd_en     = 1'b1;
        ra_cmb    = addr;
        state_nxt = LOAD;
      end
      LOAD: begin
        state_nxt = EMIT0;
      end
      EMIT0: begin
        ovalid = 1'b1;
        odata  = even_q;
        oindex = {addr, 1'b0};
        if (oready) state_nxt = EMIT1;
      end
      EMIT1: begin
        ovalid = 1'b1;
        odata  = odd_q;
        oindex = {addr, 1'b1};
        olast  = last;
        if (oready) begin
          if (last) begin
            state_nxt = IDLE;
          end else begin
            rd_en     = 1'b1;
            ra_cmb    = addr + 1'b1;
            addr_nxt  = addr + 1'b1;
            state_nxt = LOAD;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      addr   <= '0;
      ra_q   <= '0;
      even_q <= '0;
      odd_q  <= '0;
      bfp_q  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      addr   <= addr_nxt;
      done_q <= (state == EMIT1) && oready && last;
      if (rd_en) ra_q <= ra_cmb;
      if (state == LOAD) begin
        even_q <= rdr_ram0;
        odd_q  <= rdr_ram1;
      end
      if ((state == IDLE) && start) bfp_q <= ibfp;
    end
  end

  assign busy      = (state != IDLE);
  assign done      = done_q;
  assign ract_ram0 = rd_en;
  assign ract_ram1 = rd_en;
  assign ra_ram0   = ra_cmb;
  assign ra_ram1   = ra_cmb;
  assign obfp      = bfp_q;

endmodule

// File: tb/tb_fft_output_streamer.sv
// Randomized bench for fft_output_streamer: banks preloaded with address/bank
// tags, output stream compared bin by bin with the natural-order frame model.
module tb_fft_output_streamer;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int BW = 5;
  localparam int W  = 2 * DW;
  localparam int AW = N - 1;
  localparam int NB = 1 << N;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [BW-1:0] ibfp;
  logic          busy;
  logic          done;
  logic          ract_ram0;
  logic [AW-1:0] ra_ram0;
  logic [W-1:0]  rdr_ram0;
  logic          ract_ram1;
  logic [AW-1:0] ra_ram1;
  logic [W-1:0]  rdr_ram1;
  logic          ovalid;
  logic          oready;
  logic [W-1:0]  odata;
  logic [N-1:0]  oindex;
  logic          olast;
  logic [BW-1:0] obfp;

  fft_output_streamer #(
    .FFT_N(N),
    .FFT_DW(DW),
    .FFT_BFPDW(BW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .ibfp(ibfp),
    .busy(busy),
    .done(done),
    .ract_ram0(ract_ram0),
    .ra_ram0(ra_ram0),
    .rdr_ram0(rdr_ram0),
    .ract_ram1(ract_ram1),
    .ra_ram1(ra_ram1),
    .rdr_ram1(rdr_ram1),
    .ovalid(ovalid),
    .oready(oready),
    .odata(odata),
    .oindex(oindex),
    .olast(olast),
    .obfp(obfp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk;
  int nfail;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] exp_data(int k);
    return {16'(k >> 1), 16'(k & 1)};
  endfunction

  // Bank model: synchronous read, optionally garbage when not read.
  logic [W-1:0] mem0 [1<<AW];
  logic [W-1:0] mem1 [1<<AW];
  bit scramble;

  initial begin
    for (int a = 0; a < (1 << AW); a++) begin
      mem0[a] = {16'(a), 16'(0)};
      mem1[a] = {16'(a), 16'(1)};
    end
    rdr_ram0 = '0;
    rdr_ram1 = '0;
  end

  always @(posedge clk) begin
    if (ract_ram0) rdr_ram0 <= mem0[ra_ram0];
    else if (scramble) rdr_ram0 <= $urandom;
    if (ract_ram1) rdr_ram1 <= mem1[ra_ram1];
    else if (scramble) rdr_ram1 <= $urandom;
  end

  int cyc;
  always @(posedge clk) cyc++;

  // Sink ready: 0 = always, 1 = random 50%, 2 = held off by stall.
  int rdy_mode;
  bit stall;
  initial begin
    oready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       oready = 1'b1;
        1:       oready = 1'($urandom_range(0, 1));
        default: oready = !stall;
      endcase
    end
  end

  bit            mon_en;
  int            exp_k;
  logic [BW-1:0] exp_bfp;
  int            first_v;
  int            done_cnt;
  int            done_cyc;
  int            ract_cnt;
  bit            held;
  bit            prev_v;
  logic [W-1:0]  h_data;
  logic [N-1:0]  h_idx;
  logic          h_last;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("ract_eq", 64'(ract_ram1), 64'(ract_ram0));
      chk("ra_eq", 64'(ra_ram1), 64'(ra_ram0));
      if (ract_ram0) ract_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (ovalid && !prev_v && first_v < 0) first_v = cyc;
      if (ovalid) begin
        if (held) begin
          chk("hold_data", 64'(odata), 64'(h_data));
          chk("hold_idx", 64'(oindex), 64'(h_idx));
          chk("hold_last", 64'(olast), 64'(h_last));
        end
        if (oready) begin
          chk("data", 64'(odata), 64'(exp_data(exp_k)));
          chk("index", 64'(oindex), 64'(exp_k[N-1:0]));
          chk("last", 64'(olast), 64'(exp_k == NB - 1));
          chk("obfp", 64'(obfp), 64'(exp_bfp));
          chk("busy", 64'(busy), 64'(1));
          exp_k++;
          held = 1'b0;
        end else begin
          held   = 1'b1;
          h_data = odata;
          h_idx  = oindex;
          h_last = olast;
        end
      end else begin
        if (held) chk("valid_drop", 64'(ovalid), 64'(1));
        held = 1'b0;
      end
      prev_v = ovalid;
    end
  end

  int t0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_frame(logic [BW-1:0] b);
    exp_k    = 0;
    exp_bfp  = b;
    first_v  = -1;
    ract_cnt = 0;
    held     = 1'b0;
    t0       = cyc;
    start    = 1'b1;
    ibfp     = b;
    tick();
    start    = 1'b0;
    ibfp     = BW'($urandom);
  endtask

  task automatic wait_done(int budget);
    int d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) tick();
    chk("done_seen", 64'(done_cnt - d0), 64'(1));
  endtask

  task automatic wait_k(int k);
    for (int i = 0; i < 300 && exp_k != k; i++) tick();
    chk("wait_k", 64'(exp_k), 64'(k));
  endtask

  task automatic chk_zero(string p);
    chk({p, "_busy"}, 64'(busy), 64'(0));
    chk({p, "_done"}, 64'(done), 64'(0));
    chk({p, "_ract0"}, 64'(ract_ram0), 64'(0));
    chk({p, "_ract1"}, 64'(ract_ram1), 64'(0));
    chk({p, "_ovalid"}, 64'(ovalid), 64'(0));
    chk({p, "_olast"}, 64'(olast), 64'(0));
    chk({p, "_ra0"}, 64'(ra_ram0), 64'(0));
    chk({p, "_ra1"}, 64'(ra_ram1), 64'(0));
    chk({p, "_odata"}, 64'(odata), 64'(0));
    chk({p, "_oindex"}, 64'(oindex), 64'(0));
    chk({p, "_obfp"}, 64'(obfp), 64'(0));
  endtask

  initial begin
    int d0;
    rst_n    = 1'b0;
    start    = 1'b0;
    ibfp     = '0;
    mon_en   = 1'b0;
    rdy_mode = 0;
    stall    = 1'b0;
    scramble = 1'b0;
    first_v  = -1;
    repeat (3) tick();
    chk_zero("reset");
    rst_n = 1'b1;
    tick();
    mon_en = 1'b1;

    // Full-rate frame: latency, frame time, read count
    begin_frame(5'd3);
    wait_done(200);
    chk("t1_first", 64'(first_v - t0), 64'(3));
    chk("t1_done", 64'(done_cyc - t0), 64'(26));
    chk("t1_bins", 64'(exp_k), 64'(NB));
    chk("t1_ract", 64'(ract_cnt), 64'(8));
    chk("t1_pulse", 64'(done), 64'(0));
    chk("t1_busy", 64'(busy), 64'(0));
    chk("t1_obfp", 64'(obfp), 64'(3));

    // Random back-pressure
    rdy_mode = 1;
    repeat (5) tick();
    begin_frame(5'd3);
    wait_done(1000);
    chk("t2_bins", 64'(exp_k), 64'(NB));
    chk("t2_ract", 64'(ract_cnt), 64'(8));

    // Long stall at k=5 with garbage on the bank outputs, then ignored start at k=7
    rdy_mode = 2;
    stall    = 1'b0;
    repeat (3) tick();
    begin_frame(5'd3);
    wait_k(5);
    stall    = 1'b1;
    scramble = 1'b1;
    repeat (20) tick();
    chk("t3_valid", 64'(ovalid), 64'(1));
    chk("t3_idx", 64'(oindex), 64'(5));
    chk("t3_data", 64'(odata), 64'(exp_data(5)));
    stall = 1'b0;
    wait_k(7);
    d0    = done_cnt;
    start = 1'b1;
    ibfp  = 5'd9;
    tick();
    start = 1'b0;
    wait_done(300);
    chk("t4_bins", 64'(exp_k), 64'(NB));
    chk("t4_ract", 64'(ract_cnt), 64'(8));
    chk("t4_dones", 64'(done_cnt - d0), 64'(1));
    chk("t4_obfp", 64'(obfp), 64'(3));
    scramble = 1'b0;

    // Reset mid-frame at k=10
    rdy_mode = 0;
    repeat (3) tick();
    begin_frame(5'd6);
    wait_k(10);
    rst_n  = 1'b0;
    mon_en = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("t5");
    tick();
    held   = 1'b0;
    prev_v = 1'b0;
    d0     = done_cnt;
    mon_en = 1'b1;
    repeat (30) tick();
    chk("t5_nodone", 64'(done_cnt - d0), 64'(0));

    // Fresh frame, then a new start in its done cycle
    begin_frame(5'd7);
    for (int i = 0; i < 200; i++) begin
      tick();
      if (done) break;
    end
    chk("t6_sync", 64'(done), 64'(1));
    chk("t5_bins", 64'(exp_k), 64'(NB));
    begin_frame(5'd1);
    wait_done(200);
    chk("t6_first", 64'(first_v - t0), 64'(3));
    chk("t6_bins", 64'(exp_k), 64'(NB));
    chk("t6_obfp", 64'(obfp), 64'(1));

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
